// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// It works on operand magnitudes, then applies a sign fix-up in one final cycle. The latency is fixed at WIDTH+2 cycles.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [5:0]       LAST = 6'(WIDTH-1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, zero_q, zero_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

  logic [WIDTH-1:0] mag_a, mag_b, fix_q, fix_r;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH+1:0] trial;

  always_comb begin
    mag_a = (div_signed && dividend[WIDTH-1]) ? ~dividend + ONE : dividend;
    mag_b = (div_signed && divisor[WIDTH-1])  ? ~divisor + ONE  : divisor;

    // The top bit of trial is the borrow of the subtraction.
    shift_rem = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial     = {1'b0, shift_rem} - {2'b00, dvs_q};

    fix_q = quo_q;
    fix_r = rem_q[WIDTH-1:0];
    if (zero_q) begin
      fix_q = {WIDTH{1'b1}};
      fix_r = dvd_q;
    end else if (sgn_q) begin
      if (neg_a_q ^ neg_b_q) fix_q = -quo_q;
      if (neg_a_q)           fix_r = -rem_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    zero_d      = zero_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      S_IDLE: if (in_valid && !flush) begin
        state_d = S_CALC;
        cnt_d   = '0;
        sgn_d   = div_signed;
        neg_a_d = div_signed & dividend[WIDTH-1];
        neg_b_d = div_signed & divisor[WIDTH-1];
        zero_d  = (divisor == '0);
        rem_d   = '0;
        quo_d   = mag_a;
        dvs_d   = mag_b;
        dvd_d   = dividend;
      end
      S_CALC: begin
        rem_d = trial[WIDTH+1] ? shift_rem : trial[WIDTH:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        quotient_d  = fix_q;
        remainder_d = fix_r;
        state_d     = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      zero_q      <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      zero_q      <= zero_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule
